// File: rtl/tsense_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tsense_meas_ctrl
// Description : Measurement scheduler for the diode temperature-sensor SAR
//               core. It powers the core up, holds it in reset while it
//               settles, then averages 2^AVG_LOG2 fine-code samples and
//               returns the result over a valid/ack handshake.
//               Optional macro TSENSE_DISCARD_FIRST_EN drops the first
//               core_valid edge of each measurement as a settling sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tsense_meas_ctrl #(
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 4095,
    parameter int RST_CYC  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [PERIOD_W-1:0] period,
    input  logic                core_valid,
    input  logic [7:0]          core_ibf,
    output logic                core_pwrup,
    output logic                core_rst,
    output logic [7:0]          result,
    output logic                result_valid,
    input  logic                result_ack,
    output logic                busy,
    output logic                timeout_err
);

    localparam int c_ACC_W = 8 + AVG_LOG2;
    localparam int c_CNT_W = AVG_LOG2 + 1;
    localparam int c_RST_W = $clog2(RST_CYC + 1);
    localparam int c_WDG_W = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_SMP_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RST_CYC - 1);
    localparam logic [c_WDG_W-1:0] c_WDG_LAST = c_WDG_W'(TIMEOUT - 1);

`ifdef TSENSE_DISCARD_FIRST_EN
    localparam logic c_DISCARD_EN = 1'b1;
`else
    localparam logic c_DISCARD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state,       w_state_nxt;
    logic [PERIOD_W-1:0]  r_timer,       w_timer_nxt;
    logic                 r_pending,     w_pending_nxt;
    logic [c_RST_W-1:0]   r_rst_cnt,     w_rst_cnt_nxt;
    logic [c_CNT_W-1:0]   r_smp_cnt,     w_smp_cnt_nxt;
    logic [c_ACC_W-1:0]   r_acc,         w_acc_nxt;
    logic [c_WDG_W-1:0]   r_wdog,        w_wdog_nxt;
    logic                 r_discarded,   w_discarded_nxt;
    logic [7:0]           r_result,      w_result_nxt;
    logic                 r_timeout_err, w_timeout_err_nxt;
    logic                 r_valid_d;

    logic                 w_edge;
    logic                 w_skip;
    logic                 w_start;
    logic [c_ACC_W-1:0]   w_sum;
    logic [PERIOD_W-1:0]  w_period_last;

    assign w_edge        = core_valid & ~r_valid_d;
    assign w_skip        = w_edge & ~r_discarded & c_DISCARD_EN;
    assign w_sum         = r_acc + c_ACC_W'(core_ibf);
    assign w_period_last = period - PERIOD_W'(1);
    // >= rather than == so that shrinking period below the timer still fires
    assign w_start       = req | r_pending |
                           ((period != '0) && (r_timer >= w_period_last));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_pending     <= 1'b0;
            r_rst_cnt     <= '0;
            r_smp_cnt     <= '0;
            r_acc         <= '0;
            r_wdog        <= '0;
            r_discarded   <= 1'b0;
            r_result      <= '0;
            r_timeout_err <= 1'b0;
            r_valid_d     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_pending     <= w_pending_nxt;
            r_rst_cnt     <= w_rst_cnt_nxt;
            r_smp_cnt     <= w_smp_cnt_nxt;
            r_acc         <= w_acc_nxt;
            r_wdog        <= w_wdog_nxt;
            r_discarded   <= w_discarded_nxt;
            r_result      <= w_result_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_valid_d     <= core_valid;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_pending_nxt     = r_pending | (req & (r_state != S_IDLE));
        w_rst_cnt_nxt     = r_rst_cnt;
        w_smp_cnt_nxt     = r_smp_cnt;
        w_acc_nxt         = r_acc;
        w_wdog_nxt        = r_wdog;
        w_discarded_nxt   = r_discarded;
        w_result_nxt      = r_result;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt       = S_WARM;
                    w_timer_nxt       = '0;
                    w_pending_nxt     = 1'b0;
                    w_timeout_err_nxt = 1'b0;
                    w_rst_cnt_nxt     = '0;
                end else if (period != '0) begin
                    w_timer_nxt = r_timer + PERIOD_W'(1);
                end
            end
            S_WARM: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt     = S_RUN;
                    w_smp_cnt_nxt   = '0;
                    w_acc_nxt       = '0;
                    w_wdog_nxt      = '0;
                    w_discarded_nxt = 1'b0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + c_RST_W'(1);
                end
            end
            S_RUN: begin
                if (w_skip) begin
                    w_discarded_nxt = 1'b1;
                    w_wdog_nxt      = '0;
                end else if (w_edge) begin
                    w_wdog_nxt = '0;
                    // The final sample joins the sum in the same cycle it arrives
                    if (r_smp_cnt == c_SMP_LAST) begin
                        w_result_nxt = w_sum[AVG_LOG2 +: 8];
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_acc_nxt     = w_sum;
                        w_smp_cnt_nxt = r_smp_cnt + c_CNT_W'(1);
                    end
                end else if (r_wdog == c_WDG_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + c_WDG_W'(1);
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign core_pwrup   = (r_state == S_WARM) || (r_state == S_RUN);
    assign core_rst     = (r_state == S_WARM);
    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign result       = r_result;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/tsense_meas_ctrl.md
Name: tsense_meas_ctrl

Overview:
- Measurement scheduler for the diode temperature-sensor SAR core.
- Starts conversions on a request or a periodic timer, and powers the core up and down.
- Holds the core in reset while it settles, then collects 2^AVG_LOG2 fine-code samples from the core's valid pulses and averages them.
- Presents the averaged result with a valid/ack handshake.
- Sits between the core and the register/bus side of the chip.

Parameters:
- AVG_LOG2, 2: log2 of the number of samples averaged per measurement (0..4).
- PERIOD_W, 16: width of the periodic-trigger interval input.
- TIMEOUT, 4095: maximum cycles allowed between core valid rising edges before abort.
- RST_CYC, 8: number of cycles core_rst is held high at start of a measurement (minimum 6).

Ports:
- clk  in  1  system clock, 10 MHz.
- reset  in  1  synchronous active-high reset.
- req  in  1  single-cycle request to start one measurement.
- period  in  PERIOD_W  periodic trigger interval in cycles; 0 disables periodic mode.
- core_valid  in  1  core output-valid; high for 2 or more consecutive cycles per conversion.
- core_ibf  in  8  core fine code; stable while core_valid is high.
- core_pwrup  out  1  core power enable.
- core_rst  out  1  core reset.
- result  out  8  averaged temperature code.
- result_valid  out  1  result available; held until acknowledged.
- result_ack  in  1  consumer acknowledge.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky flag: the last measurement aborted on timeout.

Behaviour:
Clocking and reset:
- Single clock domain, posedge clk.
- reset is synchronous and active-high.
- Reset values: state=IDLE, core_pwrup=0, core_rst=0, result=0, result_valid=0, busy=0, timeout_err=0, accumulator=0, all counters=0, pending=0.
- Reset asserted mid-measurement takes effect on the next edge, with no partial result.

State machine:
- IDLE:
  - Period timer increments each cycle while period!=0.
  - A start fires when (req || pending || timer==period-1).
  - A start clears the timer, pending, and timeout_err, and goes to WARM.
  - req and timer expiry in the same cycle give exactly one start.
- WARM:
  - core_pwrup=1 and core_rst=1 for RST_CYC cycles.
  - Then core_rst=0 and go to RUN, with sample count=0, accumulator=0, and the watchdog cleared.
- RUN:
  - core_pwrup=1.
  - Detect a core_valid rising edge using a registered previous value; only the rising edge is counted, never the level.
  - On an edge: acc += core_ibf, sample count increments, watchdog clears.
  - When sample count reaches 2^AVG_LOG2: result <= (acc + last sample) >> AVG_LOG2, truncating. This assignment includes the final sample in the same cycle. Go to DONE.
  - The watchdog increments on cycles without an edge. When it reaches TIMEOUT: timeout_err=1, go to IDLE, no result update.
- DONE:
  - core_pwrup=0 and result_valid=1.
  - On result_ack, drop result_valid on the next edge and go to IDLE.
  - ack arriving in the same cycle result_valid first rises is honoured.

Arithmetic and counters:
- Accumulator width is 8+AVG_LOG2 bits and cannot overflow.
- With AVG_LOG2=0, result equals the single sample.

Pending requests and timer:
- A req arriving while busy sets pending. pending is one deep; extra reqs are dropped.
- A pending request starts a new measurement on the cycle after DONE→IDLE.
- The period timer is frozen while busy.
- Changing period while in IDLE: if timer ≥ period-1, the start fires on the next cycle.

Other rules:
- Results are never overwritten while result_valid=1.
- core_rst is only asserted in WARM.

Optional Feature:
- Macro: TSENSE_DISCARD_FIRST_EN.
- Defined:
  - The first core_valid rising edge after WARM is discarded (settling sample).
  - The discarded edge does not accumulate or increment the sample count, but it does clear the watchdog.
  - A measurement therefore needs 2^AVG_LOG2+1 edges.
- Undefined: every edge is accumulated.

Test Plan:
- Single measurement:
  - Stimulus: AVG_LOG2=2, req pulse; core model gives ibf 0x40, 0x42, 0x44, 0x46, each with a 2-cycle valid.
  - Required: core_rst high exactly 8 cycles; result=0x43; result_valid held until ack; core_pwrup=0 in DONE; busy falls one cycle after ack.
- Timeout:
  - Stimulus: req with no core_valid.
  - Required: after RST_CYC+TIMEOUT cycles, timeout_err=1, state IDLE, core_pwrup=0, result unchanged, result_valid=0.
  - Required: the next req clears timeout_err.
- Periodic mode:
  - Stimulus: period=100, fast core model, immediate ack.
  - Required: starts occur 100 idle cycles apart.
  - Required: with period=0, no start occurs for 1000 cycles.
- Pending requests and collision:
  - Stimulus: req three times during RUN; req coincident with timer expiry.
  - Required: exactly one extra measurement after ack; the coincidence yields one start only.
- Reset mid-run:
  - Stimulus: reset after 2 of 4 samples.
  - Required: all outputs at reset values next cycle.
  - Required: a following req produces a clean average of 4 new samples (e.g. 4×0x10 → 0x10).
- Discard-first (TSENSE_DISCARD_FIRST_EN defined):
  - Stimulus: samples 0xFF, 0x20, 0x20, 0x20, 0x20.
  - Required: result=0x20.
  - Required: without the macro, the first four samples give 0x57.
